// File: rtl/fm_pkg.sv
// Shared definitions for the FM parameter register bank: oscillator count,
// mask type, control-state encoding and the board switch field map.
package fm_pkg;

  localparam int N_OSC = 4;

  typedef logic [3:0] osc_mask_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAVE,
    S_MASK,
    S_WEIGHT
  } fm_param_state_t;

  // Switch fields: oscillator / destination mask and source mask
  localparam int SW_OSC_HI = 9;
  localparam int SW_OSC_LO = 6;
  localparam int SW_SRC_HI = 5;
  localparam int SW_SRC_LO = 2;

endpackage

// File: rtl/fm_weight_bank.sv
// 4x4 FM weight register array. A write stores one value into every cell
// selected by the row (destination) and column (source) masks.
// With FM_PARAM_SYNC_UPDATE_EN defined, writes land in a shadow array that is
// copied to the outputs when xfer_en is asserted.
module fm_weight_bank
  import fm_pkg::*;
#(
  parameter int WEIGHT_W = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    wr_en,
  input  logic [3:0]              row_mask,
  input  logic [3:0]              col_mask,
  input  logic [WEIGHT_W-1:0]     wr_data,
`ifdef FM_PARAM_SYNC_UPDATE_EN
  input  logic                    xfer_en,
`endif
  output logic [16*WEIGHT_W-1:0]  weights
);

`ifdef FM_PARAM_SYNC_UPDATE_EN

  logic [16*WEIGHT_W-1:0] shadow;

  // Merge masked writes into the shadow; publish the shadow on a transfer.
  // A transfer takes the shadow as it was before any same-cycle write.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow  <= '0;
      weights <= '0;
    end else begin
      if (xfer_en) begin
        weights <= shadow;
      end
      if (wr_en) begin
        for (int d = 0; d < N_OSC; d++) begin
          for (int s = 0; s < N_OSC; s++) begin
            if (row_mask[d] && col_mask[s]) begin
              shadow[(d*N_OSC+s)*WEIGHT_W +: WEIGHT_W] <= wr_data;
            end
          end
        end
      end
    end
  end

`else

  // Write the selected cells directly; the diagonal is included.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      weights <= '0;
    end else if (wr_en) begin
      for (int d = 0; d < N_OSC; d++) begin
        for (int s = 0; s < N_OSC; s++) begin
          if (row_mask[d] && col_mask[s]) begin
            weights[(d*N_OSC+s)*WEIGHT_W +: WEIGHT_W] <= wr_data;
          end
        end
      end
    end
  end

`endif

endmodule

// File: rtl/fm_param_regs.sv
// FM parameter register bank. Follows the load strobes of the FM control FSM,
// stages switch values while a strobe is high and commits them when it falls.
// Holds the per-oscillator waveform selects and the 4x4 FM weight matrix.
// Optional feature macro: FM_PARAM_SYNC_UPDATE_EN -- commits go to shadow
// copies that are published on the next sample_tick, so the audio path only
// ever sees complete parameter sets.
module fm_param_regs
  import fm_pkg::*;
#(
  parameter int WAVE_W   = 2,
  parameter int WEIGHT_W = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    run,
  input  logic                    load_waves,
  input  logic                    load_enables,
  input  logic                    load_weights,
  input  logic [9:0]              SW,
  input  logic                    sample_tick,
  output logic [4*WAVE_W-1:0]     wave_sel,
  output logic [16*WEIGHT_W-1:0]  fm_weight,
  output logic [3:0]              dst_mask,
  output logic [3:0]              src_mask,
  output logic                    param_update
);

  fm_param_state_t        state;
  osc_mask_t              wmask;
  logic [WAVE_W-1:0]      wval;
  logic [WEIGHT_W-1:0]    wt;

  logic                   wave_commit;
  logic                   weight_commit;
  logic                   wave_hit;
  logic                   weight_hit;
  logic [4*WAVE_W-1:0]    wave_base;
  logic [4*WAVE_W-1:0]    wave_next;

  // A commit fires in the first low-strobe cycle of a load phase, unless aborted
  assign wave_commit   = run && (state == S_WAVE)   && !load_waves;
  assign weight_commit = run && (state == S_WEIGHT) && !load_weights;

  // Only commits that select at least one register count as an update
  assign wave_hit   = wave_commit && (wmask != '0);
  assign weight_hit = weight_commit && (dst_mask != '0) && (src_mask != '0);

  // Control FSM: stage switch values while a strobe is high, return to idle on fall or abort
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      wmask    <= '0;
      wval     <= '0;
      wt       <= '0;
      dst_mask <= '0;
      src_mask <= '0;
    end else if (!run) begin
      state <= S_IDLE;
      wmask <= '0;
      wval  <= '0;
      wt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_waves) begin
            state <= S_WAVE;
            wmask <= SW[SW_OSC_HI:SW_OSC_LO];
            wval  <= SW[WAVE_W-1:0];
          end else if (load_enables) begin
            state    <= S_MASK;
            dst_mask <= SW[SW_OSC_HI:SW_OSC_LO];
            src_mask <= SW[SW_SRC_HI:SW_SRC_LO];
          end else if (load_weights) begin
            state <= S_WEIGHT;
            wt    <= SW[WEIGHT_W-1:0];
          end
        end
        S_WAVE: begin
          if (load_waves) begin
            wmask <= SW[SW_OSC_HI:SW_OSC_LO];
            wval  <= SW[WAVE_W-1:0];
          end else begin
            state <= S_IDLE;
          end
        end
        S_MASK: begin
          if (load_enables) begin
            dst_mask <= SW[SW_OSC_HI:SW_OSC_LO];
            src_mask <= SW[SW_SRC_HI:SW_SRC_LO];
          end else begin
            state <= S_IDLE;
          end
        end
        S_WEIGHT: begin
          if (load_weights) begin
            wt <= SW[WEIGHT_W-1:0];
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // New waveform vector: staged value replaces every masked oscillator field
  always_comb begin
    wave_next = wave_base;
    for (int i = 0; i < N_OSC; i++) begin
      if (wmask[i]) begin
        wave_next[i*WAVE_W +: WAVE_W] = wval;
      end
    end
  end

`ifdef FM_PARAM_SYNC_UPDATE_EN

  logic [4*WAVE_W-1:0] wave_shadow;
  logic                pending;
  logic                xfer;
  logic                xfer_d;

  assign wave_base = wave_shadow;
  assign xfer      = sample_tick && pending;

  // Shadowed outputs: commits merge into the shadow, the next tick publishes it,
  // and param_update follows the first cycle the published values are visible
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wave_shadow  <= '0;
      wave_sel     <= '0;
      pending      <= 1'b0;
      xfer_d       <= 1'b0;
      param_update <= 1'b0;
    end else begin
      if (xfer) begin
        wave_sel <= wave_shadow;
      end
      if (wave_hit) begin
        wave_shadow <= wave_next;
      end
      pending      <= wave_hit || weight_hit || (pending && !sample_tick);
      xfer_d       <= xfer;
      param_update <= xfer_d;
    end
  end

  fm_weight_bank #(
    .WEIGHT_W (WEIGHT_W)
  ) u_weight_bank (
    .Clk      (Clk),
    .Reset    (Reset),
    .wr_en    (weight_commit),
    .row_mask (dst_mask),
    .col_mask (src_mask),
    .wr_data  (wt),
    .xfer_en  (xfer),
    .weights  (fm_weight)
  );

`else

  logic unused_sample_tick;

  assign wave_base          = wave_sel;
  assign unused_sample_tick = sample_tick;

  // Direct outputs: commits land immediately and param_update marks the first cycle they show
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wave_sel     <= '0;
      param_update <= 1'b0;
    end else begin
      if (wave_hit) begin
        wave_sel <= wave_next;
      end
      param_update <= wave_hit || weight_hit;
    end
  end

  fm_weight_bank #(
    .WEIGHT_W (WEIGHT_W)
  ) u_weight_bank (
    .Clk      (Clk),
    .Reset    (Reset),
    .wr_en    (weight_commit),
    .row_mask (dst_mask),
    .col_mask (src_mask),
    .wr_data  (wt),
    .weights  (fm_weight)
  );

`endif

endmodule

// File: tb/tb_fm_param_regs.sv
// Directed bench for fm_param_regs: load sequences driven as the upstream FSM
// would, with hand-computed expected register contents after each step.
// Covers FM_PARAM_SYNC_UPDATE_EN when the macro is defined for the build.
module tb_fm_param_regs;

  localparam int WAVE_W   = 2;
  localparam int WEIGHT_W = 8;

  logic                   Clk = 1'b0;
  logic                   Reset;
  logic                   run;
  logic                   load_waves;
  logic                   load_enables;
  logic                   load_weights;
  logic [9:0]             SW;
  logic                   sample_tick;
  logic [4*WAVE_W-1:0]    wave_sel;
  logic [16*WEIGHT_W-1:0] fm_weight;
  logic [3:0]             dst_mask;
  logic [3:0]             src_mask;
  logic                   param_update;

  int checks   = 0;
  int failures = 0;

  // Free-running 10-unit clock
  always #5 Clk = ~Clk;

  fm_param_regs #(
    .WAVE_W   (WAVE_W),
    .WEIGHT_W (WEIGHT_W)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .run          (run),
    .load_waves   (load_waves),
    .load_enables (load_enables),
    .load_weights (load_weights),
    .SW           (SW),
    .sample_tick  (sample_tick),
    .wave_sel     (wave_sel),
    .fm_weight    (fm_weight),
    .dst_mask     (dst_mask),
    .src_mask     (src_mask),
    .param_update (param_update)
  );

  // Drive the control inputs and let n rising edges consume them; returns on a falling edge
  task automatic applyStimulus(input logic r, input logic lw, input logic le,
                               input logic lwt, input logic [9:0] sw, input int n);
    run          = r;
    load_waves   = lw;
    load_enables = le;
    load_weights = lwt;
    SW           = sw;
    repeat (n) @(negedge Clk);
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    Reset        = 1'b1;
    run          = 1'b0;
    load_waves   = 1'b0;
    load_enables = 1'b0;
    load_weights = 1'b0;
    SW           = '0;
    sample_tick  = 1'b0;
    repeat (2) @(negedge Clk);

    checkOutput("reset_wave",   128'(wave_sel),     128'h0);
    checkOutput("reset_weight", fm_weight,          128'h0);
    checkOutput("reset_dst",    128'(dst_mask),     128'h0);
    checkOutput("reset_src",    128'(src_mask),     128'h0);
    checkOutput("reset_update", 128'(param_update), 128'h0);

    Reset = 1'b0;
    applyStimulus(1, 0, 0, 0, 10'h000, 1);

`ifdef FM_PARAM_SYNC_UPDATE_EN

    $display("[TB] shadowed update sequence");
    applyStimulus(1, 0, 1, 0, 10'b0001_0001_00, 2);
    applyStimulus(1, 0, 0, 0, 10'h000, 1);
    applyStimulus(1, 0, 0, 1, 10'h033, 2);
    applyStimulus(1, 0, 0, 0, 10'h033, 1);
    checkOutput("sync_commit_weight", fm_weight,          128'h0);
    checkOutput("sync_commit_update", 128'(param_update), 128'h0);
    applyStimulus(1, 0, 0, 0, 10'h000, 2);
    checkOutput("sync_wait_weight",   fm_weight,          128'h0);
    sample_tick = 1'b1;
    applyStimulus(1, 0, 0, 0, 10'h000, 1);
    sample_tick = 1'b0;
    checkOutput("sync_tick_weight",   fm_weight,          128'h33);
    checkOutput("sync_tick_update",   128'(param_update), 128'h0);
    applyStimulus(1, 0, 0, 0, 10'h000, 1);
    checkOutput("sync_after_update",  128'(param_update), 128'h1);
    applyStimulus(1, 0, 0, 0, 10'h000, 1);
    checkOutput("sync_pulse_end",     128'(param_update), 128'h0);
    checkOutput("sync_hold_weight",   fm_weight,          128'h33);

`else

    $display("[TB] waveform load");
    applyStimulus(1, 1, 0, 0, 10'b1010_0000_10, 3);
    checkOutput("wave_staging",     128'(wave_sel),     128'h0);
    checkOutput("wave_staging_upd", 128'(param_update), 128'h0);
    applyStimulus(1, 0, 0, 0, 10'b1010_0000_10, 1);
    checkOutput("wave_commit",      128'(wave_sel),     128'h88);
    checkOutput("wave_commit_upd",  128'(param_update), 128'h1);
    applyStimulus(1, 0, 0, 0, 10'h000, 1);
    checkOutput("wave_upd_end",     128'(param_update), 128'h0);
    checkOutput("wave_hold",        128'(wave_sel),     128'h88);

    $display("[TB] mask select and weight load");
    applyStimulus(1, 0, 1, 0, 10'b0001_0110_00, 2);
    checkOutput("mask_dst",         128'(dst_mask),     128'h1);
    checkOutput("mask_src",         128'(src_mask),     128'h6);
    applyStimulus(1, 0, 0, 0, 10'h000, 1);
    checkOutput("mask_fall_upd",    128'(param_update), 128'h0);
    checkOutput("mask_persist_dst", 128'(dst_mask),     128'h1);
    checkOutput("mask_no_write",    fm_weight,          128'h0);
    applyStimulus(1, 0, 0, 1, 10'h05A, 2);
    checkOutput("weight_staging",   fm_weight,          128'h0);
    applyStimulus(1, 0, 0, 0, 10'h05A, 1);
    checkOutput("weight_commit",    fm_weight,          128'h5A5A00);
    checkOutput("weight_commit_upd",128'(param_update), 128'h1);
    applyStimulus(1, 0, 0, 0, 10'h000, 1);
    checkOutput("weight_upd_end",   128'(param_update), 128'h0);

    $display("[TB] abort during weight load");
    applyStimulus(1, 0, 0, 1, 10'h0FF, 2);
    applyStimulus(0, 0, 0, 1, 10'h0FF, 1);
    checkOutput("abort_weight",     fm_weight,          128'h5A5A00);
    checkOutput("abort_upd",        128'(param_update), 128'h0);
    applyStimulus(1, 0, 0, 0, 10'h0FF, 1);
    checkOutput("abort_no_commit",  fm_weight,          128'h5A5A00);
    checkOutput("abort_no_upd",     128'(param_update), 128'h0);
    applyStimulus(1, 0, 0, 1, 10'h011, 2);
    applyStimulus(1, 0, 0, 0, 10'h011, 1);
    checkOutput("post_abort_load",  fm_weight,          128'h111100);
    checkOutput("post_abort_upd",   128'(param_update), 128'h1);

    $display("[TB] rewrite with identical value");
    applyStimulus(1, 0, 0, 1, 10'h011, 2);
    applyStimulus(1, 0, 0, 0, 10'h011, 1);
    checkOutput("same_value_weight",fm_weight,          128'h111100);
    checkOutput("same_value_upd",   128'(param_update), 128'h1);

    $display("[TB] commit through empty destination mask");
    applyStimulus(1, 0, 1, 0, 10'b0000_1111_00, 2);
    applyStimulus(1, 0, 0, 0, 10'h000, 1);
    checkOutput("empty_dst",        128'(dst_mask),     128'h0);
    checkOutput("empty_src",        128'(src_mask),     128'hF);
    applyStimulus(1, 0, 0, 1, 10'h077, 2);
    applyStimulus(1, 0, 0, 0, 10'h077, 1);
    checkOutput("empty_weight",     fm_weight,          128'h111100);
    checkOutput("empty_upd",        128'(param_update), 128'h0);

    $display("[TB] diagonal write");
    applyStimulus(1, 0, 1, 0, 10'b1000_1000_00, 2);
    applyStimulus(1, 0, 0, 0, 10'h000, 1);
    applyStimulus(1, 0, 0, 1, 10'h0C3, 2);
    applyStimulus(1, 0, 0, 0, 10'h0C3, 1);
    checkOutput("diag_weight",      fm_weight,
                128'hC300_0000_0000_0000_0000_0000_0011_1100);
    checkOutput("diag_upd",         128'(param_update), 128'h1);

    $display("[TB] simultaneous strobes");
    applyStimulus(1, 1, 0, 1, 10'b0100_0000_01, 3);
    applyStimulus(1, 0, 0, 0, 10'b0100_0000_01, 1);
    checkOutput("prio_wave",        128'(wave_sel),     128'h98);
    checkOutput("prio_weight",      fm_weight,
                128'hC300_0000_0000_0000_0000_0000_0011_1100);
    checkOutput("prio_upd",         128'(param_update), 128'h1);

    $display("[TB] strobe handover");
    applyStimulus(1, 1, 0, 0, 10'b0001_0000_11, 2);
    applyStimulus(1, 0, 1, 0, 10'b0010_0100_00, 1);
    checkOutput("handover_wave",    128'(wave_sel),     128'h9B);
    checkOutput("handover_upd",     128'(param_update), 128'h1);
    checkOutput("handover_dst_old", 128'(dst_mask),     128'h8);
    applyStimulus(1, 0, 1, 0, 10'b0010_0100_00, 1);
    applyStimulus(1, 0, 0, 0, 10'h000, 1);
    checkOutput("handover_dst",     128'(dst_mask),     128'h2);
    checkOutput("handover_src",     128'(src_mask),     128'h4);

    $display("[TB] reset during waveform load");
    applyStimulus(1, 1, 0, 0, 10'b1111_0000_11, 2);
    Reset = 1'b1;
    applyStimulus(1, 1, 0, 0, 10'b1111_0000_11, 1);
    Reset = 1'b0;
    checkOutput("midreset_wave",    128'(wave_sel),     128'h0);
    applyStimulus(1, 0, 0, 0, 10'h000, 1);
    checkOutput("midreset_nocommit",128'(wave_sel),     128'h0);
    checkOutput("midreset_weight",  fm_weight,          128'h0);
    checkOutput("midreset_dst",     128'(dst_mask),     128'h0);
    checkOutput("midreset_src",     128'(src_mask),     128'h0);
    checkOutput("midreset_upd",     128'(param_update), 128'h0);

`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
